// File: rtl/float_mul.sv
// float_mul: 2-stage pipelined IEEE-754 single-precision multiplier, flush-to-zero on denormals.
// FLOAT_MUL_ROUND_EN selects round-to-nearest-even; without it the mantissa is truncated.
module float_mul #(
    parameter int float_width      = 32,
    parameter int float_exp_width  = 8,
    parameter int float_mant_width = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [float_width-1:0] a,
    input  logic [float_width-1:0] b,
    output logic                   out_valid,
    output logic [float_width-1:0] out
);
    localparam int ew = float_exp_width;
    localparam int mw = float_mant_width;
    localparam int pw = 2 * (mw + 1);
    localparam logic [ew-1:0] exp_max = '1;
    localparam logic signed [ew+1:0] bias = (ew+2)'(2**(ew-1) - 1);
`ifdef FLOAT_MUL_ROUND_EN
    localparam int kw = pw;
`else
    // truncation only needs the leading bit plus two mantissa alignments
    localparam int kw = mw + 2;
`endif

    logic [ew-1:0] ea, eb;
    logic [mw-1:0] ma, mb;
    logic a_max, b_max, a_zero, b_zero;
    assign ea = a[mw +: ew];
    assign eb = b[mw +: ew];
    assign ma = a[mw-1:0];
    assign mb = b[mw-1:0];
    assign a_max = ea == exp_max;
    assign b_max = eb == exp_max;
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;

    logic s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [ew+1:0] s1_exp;
    logic [kw-1:0] s1_prod;

    always_ff @(posedge clk) begin
        s1_valid <= rst ? 1'b0 : in_valid;
        s1_sign  <= a[float_width-1] ^ b[float_width-1];
        s1_exp   <= $signed({2'b0, ea}) + $signed({2'b0, eb}) - bias;
        s1_prod  <= kw'((pw'({1'b1, ma}) * pw'({1'b1, mb})) >> (pw - kw));
        s1_nan   <= (a_max & |ma) | (b_max & |mb) | (a_max & b_zero) | (b_max & a_zero);
        s1_inf   <= a_max | b_max;
        s1_zero  <= a_zero | b_zero;
    end

    logic norm;
    logic [mw-1:0] mant;
    logic [mw:0] mant_r;
    logic signed [ew+1:0] exp_f;
    logic [float_width-1:0] res;

    always_comb begin
        norm = s1_prod[kw-1];
        mant = norm ? s1_prod[kw-2 -: mw] : s1_prod[kw-3 -: mw];
`ifdef FLOAT_MUL_ROUND_EN
        // guard is the first dropped bit, sticky ORs everything below it
        mant_r = {1'b0, mant} + (mw+1)'((norm ? s1_prod[kw-2-mw] : s1_prod[kw-3-mw])
            & ((norm ? |s1_prod[kw-3-mw:0] : |s1_prod[kw-4-mw:0]) | mant[0]));
`else
        mant_r = {1'b0, mant};
`endif
        exp_f = s1_exp + $signed((ew+2)'(norm)) + $signed((ew+2)'(mant_r[mw]));
        res = s1_nan ? {1'b0, exp_max, 1'b1, {(mw-1){1'b0}}}
            : s1_inf ? {s1_sign, exp_max, {mw{1'b0}}}
            : s1_zero | (int'(exp_f) <= 0) ? {s1_sign, {(float_width-1){1'b0}}}
            : int'(exp_f) >= 2**ew - 1 ? {s1_sign, exp_max, {mw{1'b0}}}
            : {s1_sign, exp_f[ew-1:0], mant_r[mw-1:0]};
    end

    always_ff @(posedge clk) begin
        out_valid <= rst ? 1'b0 : s1_valid;
        out       <= rst ? '0 : s1_valid ? res : out;
    end
endmodule

// File: tb/tb_float_mul.sv
// tb_float_mul: self-checking bench for float_mul against a real-arithmetic reference model.
// Honours FLOAT_MUL_ROUND_EN the same way the design does.
module tb_float_mul;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic out_valid;
    logic [31:0] out;
    int checks = 0, errors = 0;

    typedef struct {int due; logic [31:0] val;} exp_t;

    float_mul dut (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
                   .out_valid(out_valid), .out(out));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Exact double product (24x24 bits fits in 53) then rounded/truncated to single.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic s;
        logic [7:0] ex, ey;
        logic [63:0] dp;
        real p;
        int e;
        logic [23:0] m;
        logic up;
        bit x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        s = x[31] ^ y[31];
        ex = x[30:23];
        ey = y[30:23];
        x_nan = ex == 8'hFF && x[22:0] != 0;
        y_nan = ey == 8'hFF && y[22:0] != 0;
        x_inf = ex == 8'hFF && x[22:0] == 0;
        y_inf = ey == 8'hFF && y[22:0] == 0;
        x_zero = ex == 0;
        y_zero = ey == 0;
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return 32'h7FC00000;
        if (x_inf || y_inf) return {s, 8'hFF, 23'h0};
        if (x_zero || y_zero) return {s, 31'h0};
        p = $bitstoreal({1'b0, 11'(ex + 896), x[22:0], 29'h0})
          * $bitstoreal({1'b0, 11'(ey + 896), y[22:0], 29'h0});
        dp = $realtobits(p);
        e = int'(dp[62:52]) - 896;
        m = {1'b0, dp[51:29]};
        up = 1'b0;
`ifdef FLOAT_MUL_ROUND_EN
        up = dp[28:0] > 29'h10000000 || (dp[28:0] == 29'h10000000 && m[0]);
`endif
        m = m + 24'(up);
        if (m[23]) begin
            m = '0;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [31:0] sp [6];
        int k;
        sp = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000001};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) r = sp[$urandom_range(0, 5)];
        else if (k > 2) r[30:23] = 8'($urandom_range(64, 190));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one isolated op; reports out_valid one and two edges later plus the result.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic v_early, output logic v, output logic [31:0] r);
        a = x;
        b = y;
        in_valid = 1'b1;
        step();
        v_early = out_valid;
        in_valid = 1'b0;
        step();
        v = out_valid;
        r = out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got %h, expected 00000000", out);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [31:0] xs [3], ys [3];
        logic ve, v;
        logic [31:0] r;
        xs = '{32'h00000000, 32'h3F800000, 32'h00000000};
        ys = '{32'h3F800000, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            run_op(xs[i], ys[i], ve, v, r);
            checks++;
            if (ve !== 1'b0 || v !== 1'b1) begin
                errors++;
                $display("FAIL zero_latency[%0d]: valid at +1/+2 got %b/%b, expected 0/1", i, ve, v);
            end
            checks++;
            if (r !== 32'h0) begin
                errors++;
                $display("FAIL zero_result[%0d]: got %h, expected 00000000", i, r);
            end
        end
    endtask

    task automatic test_exact();
        logic [31:0] xs [2], ys [2], ex [2];
        logic ve, v;
        logic [31:0] r;
        xs = '{32'h41000000, 32'h43480000};
        ys = '{32'h40800000, 32'h42C80000};
        ex = '{32'h42000000, 32'h469C4000};
        for (int i = 0; i < 2; i++) begin
            run_op(xs[i], ys[i], ve, v, r);
            checks++;
            if (v !== 1'b1 || r !== ex[i]) begin
                errors++;
                $display("FAIL exact[%0d]: got valid=%b %h, expected valid=1 %h", i, v, r, ex[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] xs [3], ys [3];
        logic ve, v;
        logic [31:0] r;
        xs = '{32'h3F8CCCCD, 32'h3FF33333, 32'h4121999A};
        ys = '{32'h3F8CCCCD, 32'h3FF33333, 32'h40800000};
        for (int i = 0; i < 3; i++) begin
            run_op(xs[i], ys[i], ve, v, r);
            checks++;
            if (r !== ref_mul(xs[i], ys[i])) begin
                errors++;
                $display("FAIL round[%0d]: got %h, expected %h", i, r, ref_mul(xs[i], ys[i]));
            end
            if (i == 0) begin
                checks++;
                if (int'(r) - 32'h3F9AE148 > 1 || 32'h3F9AE148 - int'(r) > 1) begin
                    errors++;
                    $display("FAIL round_1p21: got %h, expected 3F9AE148 within 1 ulp", r);
                end
            end
        end
    endtask

    task automatic test_signs();
        logic ve, v;
        logic [31:0] r, x, y;
        int d;
        for (int i = 0; i < 4; i++) begin
            x = 32'h44FA0000 | {i[0], 31'h0};
            y = 32'h40133333 | {i[1], 31'h0};
            run_op(x, y, ve, v, r);
            d = int'(r[30:0]) - 32'h458FC000;
            checks++;
            if (r[31] !== (i[0] ^ i[1]) || d > 1 || d < -1) begin
                errors++;
                $display("FAIL sign[%0d]: got %h, expected sign %b magnitude 458FC000 within 1 ulp",
                         i, r, i[0] ^ i[1]);
            end
            checks++;
            if (r !== ref_mul(x, y)) begin
                errors++;
                $display("FAIL sign_exact[%0d]: got %h, expected %h", i, r, ref_mul(x, y));
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] xs [8], ys [8], ex [8];
        logic ve, v;
        logic [31:0] r;
        xs = '{32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC00001,
               32'h00000000, 32'hFF800000, 32'h80000000, 32'hC0000000};
        ys = '{32'h00000000, 32'h40000000, 32'h00800000, 32'h3F800000,
               32'hFF800000, 32'h40000000, 32'h40A00000, 32'h00000001};
        ex = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
               32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000};
        for (int i = 0; i < 8; i++) begin
            run_op(xs[i], ys[i], ve, v, r);
            checks++;
            if (r !== ex[i]) begin
                errors++;
                $display("FAIL special[%0d]: %h*%h got %h, expected %h", i, xs[i], ys[i], r, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [4], ys [4], ex [4];
        xs = '{32'h41000000, 32'h43480000, 32'h3F8CCCCD, 32'h7F000000};
        ys = '{32'h40800000, 32'h42C80000, 32'h3F8CCCCD, 32'h40000000};
        ex = '{32'h42000000, 32'h469C4000, 32'h3F9AE148, 32'h7F800000};
        for (int i = 0; i < 5; i++) begin
            in_valid = i < 4;
            if (i < 4) begin
                a = xs[i];
                b = ys[i];
            end
            step();
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out !== ex[i-1]) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got valid=%b %h, expected valid=1 %h",
                             i - 1, out_valid, out, ex[i-1]);
                end
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out !== ex[3]) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b %h, expected valid=0 %h", out_valid, out, ex[3]);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        logic [31:0] last, x, y;
        bit have_last = 0;
        bit ev;
        for (int i = 0; i < 302; i++) begin
            x = rand_op();
            y = rand_op();
            in_valid = i < 300 && $urandom_range(0, 3) != 0;
            a = x;
            b = y;
            if (in_valid) q.push_back('{i + 1, ref_mul(x, y)});
            step();
            ev = q.size() > 0 && q[0].due == i;
            checks++;
            if (out_valid !== ev) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b, expected %b", i, out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (out !== q[0].val) begin
                    errors++;
                    $display("FAIL rand_out[%0d]: got %h, expected %h", i, out, q[0].val);
                end
                last = q[0].val;
                have_last = 1;
                void'(q.pop_front());
            end else if (have_last) begin
                checks++;
                if (out !== last) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: got %h, expected %h", i, out, last);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        a = 32'h41000000;
        b = 32'h40800000;
        in_valid = 1'b1;
        step();
        a = 32'h43480000;
        b = 32'h42C80000;
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h42000000) begin
            errors++;
            $display("FAIL rst_pre: got valid=%b %h, expected valid=1 42000000", out_valid, out);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0) begin
            errors++;
            $display("FAIL rst_flush: got valid=%b %h, expected valid=0 00000000", out_valid, out);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out !== 32'h0) begin
                errors++;
                $display("FAIL rst_stale[%0d]: got valid=%b %h, expected valid=0 00000000",
                         i, out_valid, out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_exact();
        test_rounding();
        test_signs();
        test_special();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
